// File: rtl/vga_timing_monitor.sv
// Sink-side VGA timing checker: recovers coordinates, measures line/frame length, locks after good frames.
// Optional VGA_MON_ERRCNT_EN adds a saturating err_count output.
module vga_timing_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_n,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic        rx_valid,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        locked,
  output logic        err_sticky,
`ifdef VGA_MON_ERRCNT_EN
  output logic [15:0] err_count,
`endif
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [10:0] H_TOTAL_W  = 11'(H_TOTAL);
  localparam logic [9:0]  V_TOTAL_W  = 10'(V_TOTAL);
  localparam logic [10:0] H_ACTIVE_W = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACTIVE_W = 10'(V_ACTIVE);
  localparam logic [3:0]  LOCK_W     = 4'(LOCK_FRAMES);
  localparam logic [10:0] TMO_M1     = 11'(2 * H_TOTAL - 1);

  state_t      state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d, bl_q, bl_d;
  logic [10:0] hcnt_q, hcnt_d, line_len_q, line_len_d;
  logic [9:0]  vcnt_q, vcnt_d, frame_lines_q, frame_lines_d;
  logic [9:0]  rx_x_q, rx_x_d, rx_y_q, rx_y_d;
  logic        rx_valid_q, rx_valid_d;
  logic        h_armed_q, h_armed_d, frame_err_q, frame_err_d;
  logic [3:0]  good_q, good_d;
  logic        locked_q, locked_d, err_sticky_q, err_sticky_d;
  logic [15:0] err_count_q, err_count_d;

  logic        hfall, vfall, bfall, checking;
  logic        line_err, frame_err, act_x_err, act_y_err, timeout, err_now;
  logic [10:0] hcnt_inc;
  logic [9:0]  vcnt_inc, rx_x_inc, rx_y_inc, vcnt_close, rows_close;

  always_comb begin
    hfall    = pix_en & hs_q & ~hsync;
    vfall    = pix_en & vs_q & ~vsync;
    bfall    = pix_en & bl_q & ~blank_n;
    checking = (state_q != ST_SEARCH);

    hcnt_inc = (hcnt_q == 11'h7FF) ? hcnt_q : hcnt_q + 11'd1;
    vcnt_inc = (vcnt_q == 10'h3FF) ? vcnt_q : vcnt_q + 10'd1;
    rx_x_inc = (rx_x_q == 10'h3FF) ? rx_x_q : rx_x_q + 10'd1;
    rx_y_inc = (rx_y_q == 10'h3FF) ? rx_y_q : rx_y_q + 10'd1;

    // A coincident hsync edge is counted before the frame is closed.
    vcnt_close = hfall ? vcnt_inc : vcnt_q;
    rows_close = bfall ? rx_y_inc : rx_y_q;

    line_err  = hfall & h_armed_q & checking & (hcnt_q != H_TOTAL_W);
    frame_err = vfall & checking & (vcnt_close != V_TOTAL_W);
    act_x_err = bfall & checking & (({1'b0, rx_x_q} + 11'd1) != H_ACTIVE_W);
    act_y_err = vfall & checking & (rows_close != V_ACTIVE_W);
    timeout   = pix_en & ~hfall & (hcnt_q == TMO_M1);
    err_now   = line_err | frame_err | act_x_err | act_y_err | timeout;

    state_d       = state_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    bl_d          = bl_q;
    hcnt_d        = hcnt_q;
    line_len_d    = line_len_q;
    vcnt_d        = vcnt_q;
    frame_lines_d = frame_lines_q;
    rx_x_d        = rx_x_q;
    rx_y_d        = rx_y_q;
    rx_valid_d    = rx_valid_q;
    h_armed_d     = h_armed_q;
    frame_err_d   = frame_err_q;
    good_d        = good_q;
    locked_d      = locked_q;
    err_sticky_d  = err_sticky_q | err_now;
    err_count_d   = (err_now && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;

    if (pix_en) begin
      hs_d       = hsync;
      vs_d       = vsync;
      bl_d       = blank_n;
      hcnt_d     = hfall ? 11'd1 : hcnt_inc;
      line_len_d = hfall ? hcnt_q : line_len_q;
      if (vfall) begin
        vcnt_d        = 10'd0;
        frame_lines_d = vcnt_close;
      end else if (hfall) begin
        vcnt_d = vcnt_inc;
      end
      // A timeout makes the next line length meaningless, so skip its check.
      if (timeout)    h_armed_d = 1'b0;
      else if (hfall) h_armed_d = 1'b1;
      rx_valid_d = blank_n;
      if (blank_n) rx_x_d = bl_q ? rx_x_inc : 10'd0;
      if (vfall)      rx_y_d = 10'd0;
      else if (bfall) rx_y_d = rx_y_inc;

      case (state_q)
        ST_SEARCH: begin
          locked_d = 1'b0;
          good_d   = 4'd0;
          if (vfall) begin
            state_d     = ST_TRACK;
            frame_err_d = 1'b0;
          end
        end
        ST_TRACK: begin
          if (timeout) begin
            state_d     = ST_SEARCH;
            good_d      = 4'd0;
            frame_err_d = 1'b0;
          end else if (vfall) begin
            frame_err_d = 1'b0;
            if (frame_err_q | err_now) begin
              good_d = 4'd0;
            end else begin
              good_d = good_q + 4'd1;
              if (good_q + 4'd1 == LOCK_W) begin
                state_d  = ST_LOCKED;
                locked_d = 1'b1;
              end
            end
          end else begin
            frame_err_d = frame_err_q | err_now;
          end
        end
        ST_LOCKED: begin
          if (timeout) begin
            state_d     = ST_SEARCH;
            locked_d    = 1'b0;
            good_d      = 4'd0;
            frame_err_d = 1'b0;
          end else if (err_now) begin
            state_d     = ST_TRACK;
            locked_d    = 1'b0;
            good_d      = 4'd0;
            frame_err_d = ~vfall;
          end else if (vfall) begin
            frame_err_d = 1'b0;
          end
        end
        default: begin
          state_d  = ST_SEARCH;
          locked_d = 1'b0;
          good_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_SEARCH;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      bl_q          <= 1'b0;
      hcnt_q        <= 11'd0;
      line_len_q    <= 11'd0;
      vcnt_q        <= 10'd0;
      frame_lines_q <= 10'd0;
      rx_x_q        <= 10'd0;
      rx_y_q        <= 10'd0;
      rx_valid_q    <= 1'b0;
      h_armed_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      good_q        <= 4'd0;
      locked_q      <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_count_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      bl_q          <= bl_d;
      hcnt_q        <= hcnt_d;
      line_len_q    <= line_len_d;
      vcnt_q        <= vcnt_d;
      frame_lines_q <= frame_lines_d;
      rx_x_q        <= rx_x_d;
      rx_y_q        <= rx_y_d;
      rx_valid_q    <= rx_valid_d;
      h_armed_q     <= h_armed_d;
      frame_err_q   <= frame_err_d;
      good_q        <= good_d;
      locked_q      <= locked_d;
      err_sticky_q  <= err_sticky_d;
      err_count_q   <= err_count_d;
    end
  end

  assign rx_x        = rx_x_q;
  assign rx_y        = rx_y_q;
  assign rx_valid    = rx_valid_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign locked      = locked_q;
  assign err_sticky  = err_sticky_q;
  assign dbg_state   = state_q;
`ifdef VGA_MON_ERRCNT_EN
  assign err_count   = err_count_q;
`else
  logic unused_cnt;
  assign unused_cnt  = ^err_count_q;
`endif

endmodule
